// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
//   Shared types and default constants for the push-button conditioner.
//   - btn_state_e       : per-channel debounce FSM state
//   - DEFAULT_*         : default parameter values (100 MHz board clock)
//   - btn_state_name()  : simulation-only pretty name for a state
// -----------------------------------------------------------------------------
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int DEFAULT_N_BTN         = 5;
  localparam int DEFAULT_DB_CYCLES     = 1_000_000;   // 10 ms @ 100 MHz
  localparam int DEFAULT_REPEAT_DELAY  = 50_000_000;  // 500 ms @ 100 MHz
  localparam int DEFAULT_REPEAT_PERIOD = 10_000_000;  // 100 ms @ 100 MHz

`ifndef SYNTHESIS
  function automatic string btn_state_name(btn_state_e s);
    case (s)
      IDLE:         return "IDLE";
      PRESS_WAIT:   return "PRESS_WAIT";
      HELD:         return "HELD";
      RELEASE_WAIT: return "RELEASE_WAIT";
      default:      return "UNKNOWN";
    endcase
  endfunction
`endif

endpackage

// File: rtl/button_conditioner_if.sv
// -----------------------------------------------------------------------------
// button_conditioner_if
//   Bundle of the button pins and the conditioned outputs.
//   btn_raw     : raw asynchronous pins, active-high
//   btn_level   : debounced level
//   btn_press   : 1-cycle strobe on accepted press (and auto-repeat)
//   btn_release : 1-cycle strobe on accepted release
//   master : drives the pins, consumes the conditioned outputs
//   slave  : the conditioner itself
// -----------------------------------------------------------------------------
interface button_conditioner_if #(
  parameter int N_BTN = 5
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/button_conditioner_ch.sv
// -----------------------------------------------------------------------------
// button_conditioner_ch
//   One button channel: 2-flop synchroniser, counter debounce FSM and
//   one-cycle press/release strobes. Optional auto-repeat of the press
//   strobe while held, enabled by defining AUTO_REPEAT_EN.
//   Ports:
//     clk         in  system clock
//     resetn      in  asynchronous active-low reset
//     btn_raw     in  raw asynchronous pin, active-high
//     btn_level   out debounced level
//     btn_press   out 1-cycle strobe on accepted press (and auto-repeat)
//     btn_release out 1-cycle strobe on accepted release
// -----------------------------------------------------------------------------
module button_conditioner_ch
  import button_pkg::*;
#(
  parameter int DB_CYCLES     = DEFAULT_DB_CYCLES,
  parameter int REPEAT_DELAY  = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int              CNT_W    = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1_reg, s2_reg;
  btn_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             level_reg, level_next;
  logic             press_reg, press_next;
  logic             release_reg, release_next;
  logic             fsm_press;
  logic             rpt_strobe;

  // Synchroniser and all FSM state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_reg      <= 1'b0;
      s2_reg      <= 1'b0;
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      s1_reg      <= btn_raw;
      s2_reg      <= s1_reg;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      level_reg   <= level_next;
      press_reg   <= press_next;
      release_reg <= release_next;
    end
  end

  // Debounce FSM. The counter is reset on every state change, so it never
  // needs to count past DB_CYCLES-1 and cannot wrap.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    level_next   = level_reg;
    fsm_press    = 1'b0;
    release_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (s2_reg) begin
          state_next = PRESS_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s2_reg) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = HELD;
          cnt_next   = '0;
          level_next = 1'b1;
          fsm_press  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      HELD: begin
        if (!s2_reg) begin
          state_next = RELEASE_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (s2_reg) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next   = IDLE;
          cnt_next     = '0;
          level_next   = 1'b0;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        level_next = 1'b0;
      end
    endcase
    // Repeat strobes only occur while staying in HELD, so they can never
    // coincide with a release strobe.
    press_next = fsm_press | rpt_strobe;
  end

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_reg, rpt_next;
  logic             rpt_first_reg, rpt_first_next;   // 1 until first repeat fired

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rpt_reg       <= '0;
      rpt_first_reg <= 1'b1;
    end else begin
      rpt_reg       <= rpt_next;
      rpt_first_reg <= rpt_first_next;
    end
  end

  // Counter is held at zero outside HELD, so every entry into HELD (first
  // accept or bounce back from RELEASE_WAIT) starts a fresh REPEAT_DELAY.
  always_comb begin
    rpt_next       = rpt_reg;
    rpt_first_next = rpt_first_reg;
    rpt_strobe     = 1'b0;
    if (state_reg == HELD && s2_reg) begin
      if (rpt_reg == (rpt_first_reg ? RPT_DELAY_LAST : RPT_PERIOD_LAST)) begin
        rpt_strobe     = 1'b1;
        rpt_next       = '0;
        rpt_first_next = 1'b0;
      end else begin
        rpt_next = rpt_reg + RPT_W'(1);
      end
    end else begin
      rpt_next       = '0;
      rpt_first_next = 1'b1;
    end
  end
`else
  assign rpt_strobe = 1'b0;
`endif

  assign btn_level   = level_reg;
  assign btn_press   = press_reg;
  assign btn_release = release_reg;

`ifndef SYNTHESIS
  string state_name;
  always_comb state_name = btn_state_name(state_reg);
`endif

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Front-end conditioning for the board push-buttons: N_BTN independent
//   channels of synchroniser + debounce + press/release strobes.
//   Optional feature: define AUTO_REPEAT_EN for press auto-repeat while held.
//   Ports:
//     clk     in   system clock
//     resetn  in   asynchronous active-low reset
//     btn     slave modport of button_conditioner_if
//             (btn_raw in; btn_level/btn_press/btn_release out)
// -----------------------------------------------------------------------------
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BTN         = DEFAULT_N_BTN,
  parameter int DB_CYCLES     = DEFAULT_DB_CYCLES,
  parameter int REPEAT_DELAY  = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD
) (
  input  logic                 clk,
  input  logic                 resetn,
  button_conditioner_if.slave  btn
);

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_ch
      button_conditioner_ch #(
        .DB_CYCLES     (DB_CYCLES),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_ch (
        .clk         (clk),
        .resetn      (resetn),
        .btn_raw     (btn.btn_raw[gi]),
        .btn_level   (btn.btn_level[gi]),
        .btn_press   (btn.btn_press[gi]),
        .btn_release (btn.btn_release[gi])
      );
    end
  endgenerate

endmodule
